minhash_sketch_engine: RTL and testbench
========================================

// Module: minhash_sketch_engine
// PURPOSE
//  Pipelined, multi-lane MinHash engine. Each accepted k-mer is hashed against NUM_HASHES
//  independent seeds in parallel. A running per-lane minimum is kept until the k-mer marked
//  in_last; the full signature vector is then emitted on a valid/ready output port.
//  Sits between the k-mer extractor and the sketch sorter/comparator. Replaces single-seed,
//  purely combinational hashing with a registered, back-pressurable datapath.
// PARAMETERS
//  HASHER_DATA_BITS  32  hash/k-mer/seed width W; must be >=16; all arithmetic is mod 2^W
//  NUM_HASHES        4   number of parallel seed lanes (>=1)
//  CNT_BITS          16  width of the per-sketch k-mer counter (saturating)
// PORTS
//  clk        in   1                  clock, all logic on rising edge
//  rst_n      in   1                  synchronous active-low reset
//  seeds      in   NUM_HASHES*W       lane i seed = seeds[i*W +: W]; quasi-static, must not change mid-sketch
//  in_valid   in   1                  k-mer valid
//  in_ready   out  1                  engine can accept k-mer this cycle
//  in_kmer    in   W                  packed k-mer, right-aligned
//  in_last    in   1                  final k-mer of current sketch (qualified by in_valid)
//  out_valid  out  1                  signature vector valid
//  out_ready  in   1                  downstream accepts signature
//  out_sig    out  NUM_HASHES*W       lane i minimum = out_sig[i*W +: W]
//  out_count  out  CNT_BITS           k-mers folded into this signature (saturates at all-ones)
// BEHAVIOUR
//  Hash per lane (C1..N truncated to W):
//    h = ((ROL13(seed) ^ (ROL15(kmer)*32'h1b873593)) * 5 + 32'he6546b64) mod 2^W
//    ROLr(x) = {x[W-1-r:0], x[W-1:W-r]}
//  Pipeline: three stages, enable = ~stall.
//    S1: ROL15(kmer)*C2 and ROL13(seed) registered, plus valid/last.
//    S2: xor, *5, +N registered.
//    S3: per-lane minimum accumulate.
//  Handshake:
//    in transfer = in_valid & in_ready; out transfer = out_valid & out_ready.
//    stall = out_valid & ~out_ready & s2_valid & s2_last; in_ready = ~stall.
//    While stalled, every pipeline register and accumulator holds its value.
//  Accumulator acc[i]: reset and post-sketch value is all-ones.
//    On S2 valid & ~last & ~stall: acc[i] <= min(acc[i], h[i]) (unsigned); cnt <= sat(cnt+1).
//    On S2 valid & last & ~stall:
//      out_sig[i] <= min(acc[i], h[i]); out_count <= sat(cnt+1); out_valid <= 1;
//      acc <= all-ones; cnt <= 0.
//  out_valid clears on out transfer unless a new result loads in the same cycle (then stays 1).
//  out_sig and out_count are stable while out_valid & ~out_ready.
//  Latency: in_last accepted at cycle t -> out_valid high at t+3 (no stall).
//  Throughput: 1 k-mer/cycle. Back-to-back sketches are allowed; in_last on consecutive
//    cycles yields one-kmer sketches.
//  Reset (rst_n=0 at clock edge), including mid-sketch:
//    all stage valids 0; acc all-ones; cnt 0; out_valid 0; out_sig 0; out_count 0.
//    The partial sketch is discarded. in_ready = 1 in the cycle after reset.
//  Counter saturation: cnt stops at 2^CNT_BITS-1; the min update continues normally.
//  in_last with in_valid=0 is ignored.
// TESTING (W=32, NUM_HASHES=4 unless noted)
//  1 seeds=0, single kmer 0 with last -> out_sig lanes all 32'he6546b64, out_count=1,
//    out_valid at t+3.
//  2 seed lane0=0, kmers {1, 0(last)} -> lane0 = min(32'hec43eb64, 32'he6546b64) = 32'he6546b64,
//    out_count=2.
//  3 random 1000 kmers, 4 distinct seeds, random in_valid/out_ready gaps -> each lane equals
//    the model min; no data loss or duplication.
//  4 two back-to-back single-kmer sketches with out_ready=0 -> in_ready drops when the second
//    last reaches S2; first result holds; order is preserved after out_ready=1.
//  5 rst_n pulsed low mid-sketch (3 kmers accepted) -> no out_valid; next sketch {0(last)}
//    gives 32'he6546b64, count 1.
//  6 CNT_BITS=4, 20 kmers -> out_count=15 (saturated); minimums correct.

Source files
------------

// File: rtl/minhash_sketch_engine.sv
// Multi-lane MinHash engine: hashes each k-mer against NUM_HASHES seeds and folds per-lane minimums per sketch.
// Latency: in_last accepted in cycle t -> out_valid_o in cycle t+3; throughput one k-mer per cycle.
// Backpressure: the whole pipeline freezes only when a finished sketch reaches S2 while the previous result is unread.
module minhash_sketch_engine #(
    parameter int HASHER_DATA_BITS = 32,
    parameter int NUM_HASHES       = 4,
    parameter int CNT_BITS         = 16
) (
    input  logic                                   clk_i,
    input  logic                                   rst_n_i,
    input  logic [NUM_HASHES*HASHER_DATA_BITS-1:0] seeds_i,
    input  logic                                   in_valid_i,
    output logic                                   in_ready_o,
    input  logic [HASHER_DATA_BITS-1:0]            in_kmer_i,
    input  logic                                   in_last_i,
    output logic                                   out_valid_o,
    input  logic                                   out_ready_i,
    output logic [NUM_HASHES*HASHER_DATA_BITS-1:0] out_sig_o,
    output logic [CNT_BITS-1:0]                    out_count_o
);

    localparam int W = HASHER_DATA_BITS;
    localparam logic [W-1:0] MUL_C2 = W'(32'h1b873593);
    localparam logic [W-1:0] ADD_N  = W'(32'he6546b64);
    localparam logic [W-1:0] MUL_5  = W'(5);

    function automatic logic [W-1:0] rol(input logic [W-1:0] x, input int r);
        return (x << r) | (x >> (W - r));
    endfunction

    logic [NUM_HASHES-1:0][W-1:0] seed_lane;
    assign seed_lane = seeds_i;

    // Stage 1: shared k-mer multiply plus per-lane rotated seeds
    logic                         s1_valid_q, s1_valid_d;
    logic                         s1_last_q,  s1_last_d;
    logic [W-1:0]                 s1_mul_q,   s1_mul_d;
    logic [NUM_HASHES-1:0][W-1:0] s1_rs_q,    s1_rs_d;

    // Stage 2: finished per-lane hashes
    logic                         s2_valid_q, s2_valid_d;
    logic                         s2_last_q,  s2_last_d;
    logic [NUM_HASHES-1:0][W-1:0] s2_h_q,     s2_h_d;

    // Stage 3: running minimums and the result register
    logic [NUM_HASHES-1:0][W-1:0] acc_q,      acc_d;
    logic [CNT_BITS-1:0]          cnt_q,      cnt_d;
    logic [NUM_HASHES-1:0][W-1:0] sig_q,      sig_d;
    logic [CNT_BITS-1:0]          count_q,    count_d;
    logic                         out_valid_q, out_valid_d;

    logic                         stall;
    logic                         en;
    logic [NUM_HASHES-1:0][W-1:0] h_min;
    logic [CNT_BITS-1:0]          cnt_inc;

    assign stall      = out_valid_q & ~out_ready_i & s2_valid_q & s2_last_q;
    assign en         = ~stall;
    assign in_ready_o = ~stall;

    always_comb begin
        s1_valid_d = in_valid_i;
        s1_last_d  = in_valid_i & in_last_i;
        s1_mul_d   = rol(in_kmer_i, 15) * MUL_C2;
        s1_rs_d    = '0;
        for (int i = 0; i < NUM_HASHES; i++) begin
            s1_rs_d[i] = rol(seed_lane[i], 13);
        end
    end

    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_last_d  = s1_last_q;
        s2_h_d     = '0;
        for (int i = 0; i < NUM_HASHES; i++) begin
            s2_h_d[i] = ((s1_rs_q[i] ^ s1_mul_q) * MUL_5) + ADD_N;
        end
    end

    always_comb begin
        h_min = '0;
        for (int i = 0; i < NUM_HASHES; i++) begin
            h_min[i] = (s2_h_q[i] < acc_q[i]) ? s2_h_q[i] : acc_q[i];
        end
        cnt_inc = (cnt_q == {CNT_BITS{1'b1}}) ? cnt_q : cnt_q + CNT_BITS'(1);

        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sig_d       = sig_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
        // A new result may load in the same cycle the old one is taken
        if (en && s2_valid_q) begin
            if (s2_last_q) begin
                sig_d       = h_min;
                count_d     = cnt_inc;
                out_valid_d = 1'b1;
                acc_d       = '1;
                cnt_d       = '0;
            end else begin
                acc_d = h_min;
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_mul_q   <= '0;
            s1_rs_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_h_q     <= '0;
        end else if (en) begin
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_mul_q   <= s1_mul_d;
            s1_rs_q    <= s1_rs_d;
            s2_valid_q <= s2_valid_d;
            s2_last_q  <= s2_last_d;
            s2_h_q     <= s2_h_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            acc_q       <= '1;
            cnt_q       <= '0;
            sig_q       <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sig_q       <= sig_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_sig_o   = sig_q;
    assign out_count_o = count_q;

endmodule

// File: tb/tb_minhash_sketch_engine.sv
// Directed bench for minhash_sketch_engine: a 16-bit-counter instance and a 4-bit-counter instance share stimulus.
module tb_minhash_sketch_engine;

    logic         clk;
    logic         rst_n;
    logic [127:0] seeds;
    logic         in_valid;
    logic [31:0]  in_kmer;
    logic         in_last;
    logic         out_ready;

    logic         a_in_ready, a_out_valid;
    logic [127:0] a_out_sig;
    logic [15:0]  a_out_count;
    logic         b_in_ready, b_out_valid;
    logic [127:0] b_out_sig;
    logic [3:0]   b_out_count;

    int passes = 0;
    int checks = 0;

    minhash_sketch_engine #(.HASHER_DATA_BITS(32), .NUM_HASHES(4), .CNT_BITS(16)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .seeds_i(seeds),
        .in_valid_i(in_valid), .in_ready_o(a_in_ready), .in_kmer_i(in_kmer), .in_last_i(in_last),
        .out_valid_o(a_out_valid), .out_ready_i(out_ready), .out_sig_o(a_out_sig), .out_count_o(a_out_count)
    );

    minhash_sketch_engine #(.HASHER_DATA_BITS(32), .NUM_HASHES(4), .CNT_BITS(4)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .seeds_i(seeds),
        .in_valid_i(in_valid), .in_ready_o(b_in_ready), .in_kmer_i(in_kmer), .in_last_i(in_last),
        .out_valid_o(b_out_valid), .out_ready_i(out_ready), .out_sig_o(b_out_sig), .out_count_o(b_out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] hmod(input logic [31:0] seed, input logic [31:0] kmer);
        logic [31:0] rs, rk, m;
        rs = {seed[18:0], seed[31:19]};
        rk = {kmer[16:0], kmer[31:17]};
        m  = rk * 32'h1b873593;
        return ((rs ^ m) * 32'd5) + 32'he6546b64;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!a_out_valid && n < 20) begin
            tick;
            n++;
        end
        check(tag, a_out_valid, 1'b1);
    endtask

    task automatic send(input logic [31:0] k, input logic l);
        in_valid = 1'b1;
        in_kmer  = k;
        in_last  = l;
        tick;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    localparam logic [127:0] SEEDS_MIX = {32'hdeadbeef, 32'h0f0f0f0f, 32'h9abcdef0, 32'h12345678};

    logic [31:0]  m_acc [4];
    int           m_cnt;
    logic [127:0] q_sig [$];
    int           q_cnt [$];
    logic [31:0]  h;
    logic [127:0] exp_sig;
    int           sent, cyc;

    initial begin
        rst_n = 1'b0; seeds = '0; in_valid = 1'b0; in_kmer = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) tick;
        rst_n = 1'b1;
        check("reset_out_valid", a_out_valid, 1'b0);
        check("reset_out_sig",   a_out_sig, 128'h0);
        check("reset_out_count", a_out_count, 16'h0);
        check("reset_in_ready",  a_in_ready, 1'b1);

        // single k-mer 0, all seeds 0, exact latency
        send(32'h0, 1'b1);
        check("t1_lat1", a_out_valid, 1'b0);
        tick;
        check("t1_lat2", a_out_valid, 1'b0);
        tick;
        check("t1_lat3", a_out_valid, 1'b1);
        check("t1_sig",   a_out_sig, {4{32'he6546b64}});
        check("t1_count", a_out_count, 16'd1);
        tick;
        check("t1_clear", a_out_valid, 1'b0);

        // kmers {1, 0(last)}
        send(32'h1, 1'b0);
        send(32'h0, 1'b1);
        wait_out("t2_valid");
        check("t2_sig",   a_out_sig, {4{32'he6546b64}});
        check("t2_count", a_out_count, 16'd2);
        tick;

        // stray in_last without in_valid, then single kmer 1
        in_last = 1'b1;
        tick;
        in_last = 1'b0;
        send(32'h1, 1'b1);
        wait_out("t2b_valid");
        check("t2b_sig",   a_out_sig, {4{32'hec43eb64}});
        check("t2b_count", a_out_count, 16'd1);
        tick;

        // back-to-back single-kmer sketches with downstream stalled
        out_ready = 1'b0;
        send(32'h0, 1'b1);
        send(32'h1, 1'b1);
        tick;
        check("t4_valid",     a_out_valid, 1'b1);
        check("t4_in_ready0", a_in_ready, 1'b0);
        check("t4_sig0",      a_out_sig, {4{32'he6546b64}});
        repeat (3) tick;
        check("t4_hold_sig",   a_out_sig, {4{32'he6546b64}});
        check("t4_hold_count", a_out_count, 16'd1);
        check("t4_hold_rdy",   a_in_ready, 1'b0);
        out_ready = 1'b1;
        #1;
        check("t4_rdy_back", a_in_ready, 1'b1);
        tick;
        check("t4_valid2", a_out_valid, 1'b1);
        check("t4_sig1",   a_out_sig, {4{32'hec43eb64}});
        check("t4_count1", a_out_count, 16'd1);
        tick;
        check("t4_drained", a_out_valid, 1'b0);

        // reset mid-sketch
        send(32'h5, 1'b0);
        send(32'h6, 1'b0);
        send(32'h7, 1'b0);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        check("t5_in_ready", a_in_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("t5_no_valid", a_out_valid, 1'b0);
            tick;
        end
        send(32'h0, 1'b1);
        wait_out("t5_valid");
        check("t5_sig",   a_out_sig, {4{32'he6546b64}});
        check("t5_count", a_out_count, 16'd1);
        tick;

        // 20 kmers: counter saturation on the 4-bit instance
        seeds = SEEDS_MIX;
        for (int l = 0; l < 4; l++) m_acc[l] = 32'hffffffff;
        for (int i = 0; i < 20; i++) begin
            in_kmer = 32'h01234567 * (i + 3) + 32'h9e3779b9 * i;
            for (int l = 0; l < 4; l++) begin
                h = hmod(seeds[l*32 +: 32], in_kmer);
                if (h < m_acc[l]) m_acc[l] = h;
            end
            send(in_kmer, i == 19);
        end
        exp_sig = {m_acc[3], m_acc[2], m_acc[1], m_acc[0]};
        wait_out("t6_valid");
        check("t6_b_valid", b_out_valid, 1'b1);
        check("t6_a_count", a_out_count, 16'd20);
        check("t6_b_count", b_out_count, 4'd15);
        check("t6_a_sig",   a_out_sig, exp_sig);
        check("t6_b_sig",   b_out_sig, exp_sig);
        tick;

        // random traffic with gaps on both sides
        for (int l = 0; l < 4; l++) m_acc[l] = 32'hffffffff;
        m_cnt = 0;
        sent  = 0;
        cyc   = 0;
        while ((sent < 1000 || q_sig.size() > 0) && cyc < 20000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (sent < 1000) begin
                in_valid = ($urandom_range(0, 2) != 0);
                in_kmer  = $urandom;
                in_last  = (sent == 999) || ($urandom_range(0, 15) == 0);
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            #1;
            if (a_out_valid && out_ready) begin
                if (q_sig.size() == 0) begin
                    check("t3_unexpected", a_out_valid, 1'b0);
                end else begin
                    check("t3_sig",   a_out_sig, q_sig.pop_front());
                    check("t3_count", a_out_count, q_cnt.pop_front());
                end
            end
            if (in_valid && a_in_ready) begin
                for (int l = 0; l < 4; l++) begin
                    h = hmod(seeds[l*32 +: 32], in_kmer);
                    if (h < m_acc[l]) m_acc[l] = h;
                end
                m_cnt++;
                sent++;
                if (in_last) begin
                    q_sig.push_back({m_acc[3], m_acc[2], m_acc[1], m_acc[0]});
                    q_cnt.push_back(m_cnt);
                    for (int l = 0; l < 4; l++) m_acc[l] = 32'hffffffff;
                    m_cnt = 0;
                end
            end
            tick;
            cyc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("t3_all_sent", sent, 1000);
        check("t3_drained",  q_sig.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
